dmem_responder: RTL and testbench

//   Data-memory responder for the pipelined core's MEM-stage interface (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).

---
 rtl/dmem_responder_pkg.sv | 13 +
 rtl/dmem_ram.sv | 44 ++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int DMEM_CNT_W = 4;
  localparam int DMEM_LANES = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with byte-lane write enables and a registered read port.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DMEM_LANES-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  // Storage array: no reset so contents survive a core reset
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < DMEM_LANES; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data register, only disturbed by read accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated MEM-stage data memory with pipeline stall and bad-access flag.
// Build option DMEM_WSTRB_EN adds byte-lane write strobes on port mem_wstrb.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
`ifdef DMEM_WSTRB_EN
  input  logic [3:0]  mem_wstrb,
`endif
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(WAIT_STATES - 1);

  dmem_state_e             r_state;
  logic [DMEM_CNT_W-1:0]   r_cnt;
  logic                    r_we;
  logic                    r_bad;
  logic                    r_err;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [31:0]             r_din;
  logic [DMEM_LANES-1:0]   r_be;

  logic                    w_req;
  logic                    w_bad;
  logic                    w_commit;
  logic                    w_ram_en;
  logic [31:0]             w_off;
  logic [31:0]             w_ram_q;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [DMEM_LANES-1:0]   w_be;

  assign w_req = mem_ren | mem_wen;
  assign w_off = mem_addr - BASE_ADDR;
  assign w_idx = w_off[ADDR_WIDTH+1:2];

  // BASE_ADDR is word aligned, so offset alignment equals address alignment
  assign w_bad = (mem_ren & mem_wen)
               | (w_off[1:0] != 2'b00)
               | (mem_addr < BASE_ADDR)
               | (w_off[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});

`ifdef DMEM_WSTRB_EN
  assign w_be = mem_wstrb;
`else
  assign w_be = 4'hF;
`endif

  assign w_commit = (r_state == DMEM_BUSY) && (r_cnt == {DMEM_CNT_W{1'b0}});

  // Reads are launched on acceptance so data is ready at commit; writes land on the commit edge
  assign w_ram_en   = ((r_state == DMEM_IDLE) & mem_ren & ~w_bad) | (w_commit & r_we & ~r_bad);
  assign w_ram_addr = w_commit ? r_idx : w_idx;

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_ram_en),
    .i_we    (w_commit),
    .i_be    (r_be),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign mem_stall = rst_n & (((r_state == DMEM_IDLE) & w_req) | (r_state == DMEM_BUSY));
  assign mem_din   = r_din;
  assign mem_err   = r_err;

  // Access sequencer with request latches and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DMEM_IDLE;
      r_cnt   <= {DMEM_CNT_W{1'b0}};
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= {ADDR_WIDTH{1'b0}};
      r_wdata <= 32'd0;
      r_din   <= 32'd0;
      r_be    <= {DMEM_LANES{1'b0}};
    end else begin
      case (r_state)
        DMEM_IDLE: begin
          r_err <= 1'b0;
          if (w_req) begin
            r_we    <= mem_wen;
            r_bad   <= w_bad;
            r_idx   <= w_idx;
            r_wdata <= mem_dout;
            r_be    <= w_be;
            r_cnt   <= CNT_LOAD;
            r_state <= DMEM_BUSY;
          end else begin
            r_state <= DMEM_IDLE;
          end
        end
        DMEM_BUSY: begin
          if (r_cnt != {DMEM_CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(DMEM_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_state <= DMEM_DONE;
            r_err   <= r_bad;
            if (r_bad) begin
              r_din <= 32'd0;
            end else if (!r_we) begin
              r_din <= w_ram_q;
            end else begin
              r_din <= r_din;
            end
          end
        end
        DMEM_DONE: begin
          r_err   <= 1'b0;
          r_state <= DMEM_IDLE;
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= DMEM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (1 and 3 wait states, different bases).
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WS_A  = 1;
  localparam int WS_B  = 3;
  localparam int LAT_A = WS_A + 1;
  localparam int LAT_B = WS_B + 1;

  typedef struct {
    logic [31:0] din;
    logic        chk_din;
    logic        err;
    int          stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_ren, a_wen, b_ren, b_wen;
  logic [31:0] a_addr, a_dout, b_addr, b_dout;
  logic [3:0]  a_strb, b_strb;
  logic [31:0] a_din, b_din;
  logic        a_stall, a_err, b_stall, b_err;

  exp_t q0[$];
  exp_t q1[$];
  int   run[2];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(WS_A)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (a_ren),
    .mem_wen   (a_wen),
    .mem_addr  (a_addr),
    .mem_dout  (a_dout),
`ifdef DMEM_WSTRB_EN
    .mem_wstrb (a_strb),
`endif
    .mem_din   (a_din),
    .mem_stall (a_stall),
    .mem_err   (a_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(WS_B)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (b_ren),
    .mem_wen   (b_wen),
    .mem_addr  (b_addr),
    .mem_dout  (b_dout),
`ifdef DMEM_WSTRB_EN
    .mem_wstrb (b_strb),
`endif
    .mem_din   (b_din),
    .mem_stall (b_stall),
    .mem_err   (b_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: accumulates stall length and scores each completion against the queue head
  task automatic mon_step(input int id, input logic st, input logic er, input logic [31:0] din);
    exp_t e;
    if (!rst_n) begin
      run[id] = 0;
    end else if (st) begin
      run[id]++;
      chk($sformatf("err_during_stall id=%0d", id), {31'd0, er}, 32'd0);
    end else if (run[id] > 0) begin
      checks++;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        failures++;
        $display("FAIL unexpected_done id=%0d got completion want none", id);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (run[id] != e.stall) begin
          failures++;
          $display("FAIL stall_len id=%0d got=%0d want=%0d", id, run[id], e.stall);
        end
        chk($sformatf("done_err id=%0d", id), {31'd0, er}, {31'd0, e.err});
        if (e.chk_din) chk($sformatf("done_din id=%0d", id), din, e.din);
      end
      run[id] = 0;
    end else begin
      chk($sformatf("err_idle id=%0d", id), {31'd0, er}, 32'd0);
    end
  endtask

  always @(negedge clk) mon_step(0, a_stall, a_err, a_din);
  always @(negedge clk) mon_step(1, b_stall, b_err, b_din);

  task automatic drive(input int id, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (id == 0) begin
      a_ren = ren; a_wen = wen; a_addr = addr; a_dout = data; a_strb = strb;
    end else begin
      b_ren = ren; b_wen = wen; b_addr = addr; b_dout = data; b_strb = strb;
    end
  endtask

  task automatic access(input int id, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic chk_din, input logic [31:0] din, input logic err);
    exp_t e;
    int   n;
    logic st;
    e.din = din; e.chk_din = chk_din; e.err = err;
    e.stall = (id == 0) ? LAT_A : LAT_B;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    drive(id, ren, wen, addr, data, strb);
    n  = 0;
    st = 1'b1;
    while (st && n < 40) begin
      @(negedge clk);
      n++;
      st = (id == 0) ? a_stall : b_stall;
    end
    if (st) begin
      checks++;
      failures++;
      $display("FAIL done_timeout id=%0d got stall still high want DONE within 40 cycles", id);
    end
  endtask

  task automatic idle(input int id);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall_a", {31'd0, a_stall}, 32'd0);
    chk("rst_err_a",   {31'd0, a_err},   32'd0);
    chk("rst_din_a",   a_din,            32'd0);
    chk("rst_din_b",   b_din,            32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write/read, back to back, including the top word of the window
    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_0000, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 32'h1234_5678, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h1234_5678, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b1, 32'hCAFE_F00D, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0A0A, 4'hF, 1'b1, 32'hCAFE_F00D, 1'b0);
    // Bad accesses: misaligned and out of range, reads and writes
    access(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         4'hF, 1'b1, 32'h0000_0000, 1'b1);
    access(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b1, 32'h0000_0000, 1'b1);
    access(0, 1'b0, 1'b1, 32'h0000_0011, 32'hBAD0_BAD0, 4'hF, 1'b1, 32'h0000_0000, 1'b1);
    access(0, 1'b0, 1'b1, 32'h0000_1000, 32'hBAD1_BAD1, 4'hF, 1'b1, 32'h0000_0000, 1'b1);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 32'h1234_5678, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b1, 32'h0000_0A0A, 1'b0);
    // ren and wen together
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 4'hF, 1'b1, 32'h0000_0A0A, 1'b0);
    access(0, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000, 1'b1);
    access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b1, 32'h2020_2020, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0040, 32'h5555_5555, 4'hF, 1'b1, 32'h2020_2020, 1'b0);
    idle(0);

    // Write aborted by reset while BUSY
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {31'd0, a_stall}, 32'd0);
    chk("abort_err",   {31'd0, a_err},   32'd0);
    chk("abort_din",   a_din,            32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 1'b1, 32'h5555_5555, 1'b0);

`ifdef DMEM_WSTRB_EN
    access(0, 1'b0, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h5555_5555, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0000, 4'h5, 1'b1, 32'h5555_5555, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         4'hF, 1'b1, 32'hFF00_FF00, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0080, 32'h1234_1234, 4'h0, 1'b1, 32'hFF00_FF00, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         4'hF, 1'b1, 32'hFF00_FF00, 1'b0);
`endif
    idle(0);

    // Three wait states, window based at 0x2000
    access(1, 1'b0, 1'b1, 32'h0000_2000, 32'h3333_0000, 4'hF, 1'b1, 32'h0000_0000, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 1'b1, 32'h3333_0000, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_1FFC, 32'h0,         4'hF, 1'b1, 32'h0000_0000, 1'b1);
    access(1, 1'b0, 1'b1, 32'h0000_2FFC, 32'h4444_4444, 4'hF, 1'b0, 32'h0000_0000, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_2FFC, 32'h0,         4'hF, 1'b1, 32'h4444_4444, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'hF, 1'b1, 32'h0000_0000, 1'b1);
    idle(1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue0_drained", q0.size(), 32'd0);
    chk("queue1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
